// File: rtl/vram_write_arbiter_if.sv
// Write-side bus of the vram write arbiter: two pixel-writer handshakes, the
// frame-clear control/status and the registered vram write port.
//   master : the side that issues writes/clears (writers, host, bench)
//   slave  : the arbiter itself
// Signals:
//   req0_valid/ready/adr/dat  requester 0 write handshake
//   req1_valid/ready/adr/dat  requester 1 write handshake
//   clr_start, clr_dat        frame-clear request and fill value
//   clr_busy, clr_done        frame-clear status
//   vram_we/adr_w/dat_w       video-memory write port
interface vram_write_arbiter_if #(
    parameter int MAW = 19,
    parameter int MDW = 8
) ();
    logic           req0_valid;
    logic           req0_ready;
    logic [MAW-1:0] req0_adr;
    logic [MDW-1:0] req0_dat;
    logic           req1_valid;
    logic           req1_ready;
    logic [MAW-1:0] req1_adr;
    logic [MDW-1:0] req1_dat;
    logic           clr_start;
    logic [MDW-1:0] clr_dat;
    logic           clr_busy;
    logic           clr_done;
    logic           vram_we;
    logic [MAW-1:0] vram_adr_w;
    logic [MDW-1:0] vram_dat_w;

    modport master (
        output req0_valid, req0_adr, req0_dat,
        output req1_valid, req1_adr, req1_dat,
        output clr_start, clr_dat,
        input  req0_ready, req1_ready, clr_busy, clr_done,
        input  vram_we, vram_adr_w, vram_dat_w
    );

    modport slave (
        input  req0_valid, req0_adr, req0_dat,
        input  req1_valid, req1_adr, req1_dat,
        input  clr_start, clr_dat,
        output req0_ready, req1_ready, clr_busy, clr_done,
        output vram_we, vram_adr_w, vram_dat_w
    );
endinterface

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter
// Shares the single video-memory write port between two pixel writers with
// round-robin arbitration, and contains a frame-clear sequencer that fills
// FRAME_PIXELS words (addresses 0..FRAME_PIXELS-1) with one colour index.
// Ports:
//   clk     clock
//   clk_en  clock enable; all state advances only when high, readys forced 0
//   rst_n   synchronous active-low reset
//   bus     slave side of vram_write_arbiter_if (requesters, clear, vram port)
module vram_write_arbiter #(
    parameter int MAW          = 19,
    parameter int MDW          = 8,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                 clk,
    input  logic                 clk_en,
    input  logic                 rst_n,
    vram_write_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [MAW-1:0] LAST_ADR = MAW'(FRAME_PIXELS - 1);

    state_t         state_reg, state_next;
    logic           prio_reg, prio_next;
    logic [MAW-1:0] cnt_reg, cnt_next;
    logic [MDW-1:0] clr_dat_reg, clr_dat_next;
    logic           we_reg, we_next;
    logic [MAW-1:0] adr_reg, adr_next;
    logic [MDW-1:0] dat_reg, dat_next;
    logic           ready0, ready1;
    logic           grant0, grant1;

    // A lone requester always wins; on contention prio names the winner.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | ~prio_reg);
    assign grant1 = bus.req1_valid & (~bus.req0_valid |  prio_reg);

    always_comb begin
        state_next   = state_reg;
        prio_next    = prio_reg;
        cnt_next     = cnt_reg;
        clr_dat_next = clr_dat_reg;
        we_next      = 1'b0;
        adr_next     = adr_reg;
        dat_next     = dat_reg;
        ready0       = 1'b0;
        ready1       = 1'b0;
        case (state_reg)
            ST_ARB: begin
                // A clear request pre-empts both writers for this cycle.
                ready0 = clk_en & ~bus.clr_start & grant0;
                ready1 = clk_en & ~bus.clr_start & grant1;
                if (bus.clr_start) begin
                    state_next   = ST_CLEAR;
                    cnt_next     = '0;
                    clr_dat_next = bus.clr_dat;
                end else if (grant0) begin
                    we_next   = 1'b1;
                    adr_next  = bus.req0_adr;
                    dat_next  = bus.req0_dat;
                    prio_next = 1'b1;
                end else if (grant1) begin
                    we_next   = 1'b1;
                    adr_next  = bus.req1_adr;
                    dat_next  = bus.req1_dat;
                    prio_next = 1'b0;
                end
            end
            ST_CLEAR: begin
                we_next  = 1'b1;
                adr_next = cnt_reg;
                dat_next = clr_dat_reg;
                // Counter stops at the last address; it never wraps.
                if (cnt_reg == LAST_ADR) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + MAW'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_ARB;
            end
            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    // Reset wins over clk_en so a clear can always be aborted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_ARB;
            prio_reg    <= 1'b0;
            cnt_reg     <= '0;
            clr_dat_reg <= '0;
            we_reg      <= 1'b0;
            adr_reg     <= '0;
            dat_reg     <= '0;
        end else if (clk_en) begin
            state_reg   <= state_next;
            prio_reg    <= prio_next;
            cnt_reg     <= cnt_next;
            clr_dat_reg <= clr_dat_next;
            we_reg      <= we_next;
            adr_reg     <= adr_next;
            dat_reg     <= dat_next;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.clr_busy   = (state_reg == ST_CLEAR);
    assign bus.clr_done   = (state_reg == ST_DONE);
    assign bus.vram_we    = we_reg;
    assign bus.vram_adr_w = adr_reg;
    assign bus.vram_dat_w = dat_reg;
endmodule
